// File: rtl/dct_coef_accumulator.sv
// dct_coef_accumulator
//   Multiply-accumulate back end for the DCT datapath. It sums N_TERMS
//   consecutive signed products into one coefficient and saturates the sum
//   to OUT_W bits. The result is presented through a one-entry valid/ready
//   output register, and each coefficient is tagged with its index in the row.
//
// Ports
//   i_clk, i_rst      rising-edge clock, synchronous active-high reset
//   i_prod_valid      i_product is valid this cycle
//   i_product         signed IN_W-bit product
//   o_prod_ready      product accepted this cycle (combinational)
//   i_flush           drop the partial sum and zero the index counter
//   o_coef_valid      output register holds a coefficient
//   o_coef            saturated coefficient
//   o_coef_idx        index of the held coefficient
//   o_coef_sat        held coefficient was clipped
//   i_coef_ready      consumer takes the coefficient this cycle
//   o_busy            partial accumulation in progress
module dct_coef_accumulator #(
  parameter int N_TERMS = 8,
  parameter int IN_W    = 16,
  parameter int OUT_W   = 16,
  parameter int IDX_W   = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_prod_valid,
  input  logic [IN_W-1:0]  i_product,
  output logic             o_prod_ready,
  input  logic             i_flush,
  output logic             o_coef_valid,
  output logic [OUT_W-1:0] o_coef,
  output logic [IDX_W-1:0] o_coef_idx,
  output logic             o_coef_sat,
  input  logic             i_coef_ready,
  output logic             o_busy
);

  localparam int CNT_W = $clog2(N_TERMS);
  localparam int ACC_W = IN_W + CNT_W;

  localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(N_TERMS - 1);

  // Saturation bounds expressed at accumulator width.
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // Bit 0 marks a partial sum in progress and bit 1 a held coefficient,
  // so ACCUM and HOLD can coexist as ACCUM_HOLD.
  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    ACCUM      = 2'b01,
    HOLD       = 2'b10,
    ACCUM_HOLD = 2'b11
  } state_t;

  state_t                    state, state_nxt;
  logic [CNT_W-1:0]          term_cnt, term_cnt_nxt;
  logic signed [ACC_W-1:0]   acc, acc_nxt;
  logic [IDX_W-1:0]          idx_cnt, idx_cnt_nxt;
  logic [OUT_W-1:0]          coef_q, coef_nxt;
  logic [IDX_W-1:0]          coef_idx_q, coef_idx_nxt;
  logic                      sat_q, sat_nxt;

  logic                      hold;
  logic                      hold_nxt;
  logic                      last;
  logic                      accept;
  logic                      complete;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   sum;
  logic                      clip_hi;
  logic                      clip_lo;
  logic [OUT_W-1:0]          sat_val;

  assign hold = (state == HOLD) || (state == ACCUM_HOLD);

  // Datapath: sign-extended sum of the running total and the new product.
  always_comb begin
    prod_ext = {{CNT_W{i_product[IN_W-1]}}, i_product};
    last     = (term_cnt == LAST_TERM);
    // Only the final term of a row needs a free output slot.
    o_prod_ready = !i_flush && (!last || !hold || i_coef_ready);
    accept   = i_prod_valid && o_prod_ready;
    complete = accept && last;
    sum      = (term_cnt == '0) ? prod_ext : acc + prod_ext;
    clip_hi  = (sum > SAT_MAX);
    clip_lo  = (sum < SAT_MIN);
    if (clip_hi) begin
      sat_val = SAT_MAX[OUT_W-1:0];
    end else if (clip_lo) begin
      sat_val = SAT_MIN[OUT_W-1:0];
    end else begin
      sat_val = sum[OUT_W-1:0];
    end
  end

  // Next-state and next-register values.
  always_comb begin
    term_cnt_nxt = term_cnt;
    acc_nxt      = acc;
    idx_cnt_nxt  = idx_cnt;
    coef_nxt     = coef_q;
    coef_idx_nxt = coef_idx_q;
    sat_nxt      = sat_q;
    hold_nxt     = hold;

    if (i_flush) begin
      term_cnt_nxt = '0;
      acc_nxt      = '0;
      idx_cnt_nxt  = '0;
    end else if (accept) begin
      term_cnt_nxt = term_cnt + 1'b1;
      acc_nxt      = sum;
      if (complete) begin
        idx_cnt_nxt = idx_cnt + 1'b1;
      end
    end

    // A completion in the same cycle as a drain refills the register.
    if (complete) begin
      coef_nxt     = sat_val;
      coef_idx_nxt = idx_cnt;
      sat_nxt      = clip_hi || clip_lo;
      hold_nxt     = 1'b1;
    end else if (hold && i_coef_ready) begin
      hold_nxt     = 1'b0;
    end

    state_nxt = state_t'({hold_nxt, (term_cnt_nxt != '0)});
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      term_cnt   <= '0;
      acc        <= '0;
      idx_cnt    <= '0;
      coef_q     <= '0;
      coef_idx_q <= '0;
      sat_q      <= 1'b0;
    end else begin
      state      <= state_nxt;
      term_cnt   <= term_cnt_nxt;
      acc        <= acc_nxt;
      idx_cnt    <= idx_cnt_nxt;
      coef_q     <= coef_nxt;
      coef_idx_q <= coef_idx_nxt;
      sat_q      <= sat_nxt;
    end
  end

  assign o_coef_valid = hold;
  assign o_coef       = coef_q;
  assign o_coef_idx   = coef_idx_q;
  assign o_coef_sat   = sat_q;
  assign o_busy       = (state == ACCUM) || (state == ACCUM_HOLD);

endmodule
